// File: rtl/vector_mem_controller_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the vector memory controller: data-cache request/status codes,
// element-size codes and the controller state encoding.
package vector_mem_controller_pkg;

    localparam logic [2:0] ONE_BYTE   = 3'd0;
    localparam logic [2:0] TWO_BYTE   = 3'd1;
    localparam logic [2:0] FOUR_BYTE  = 3'd2;
    localparam logic [2:0] EIGHT_BYTE = 3'd3;

    localparam logic [1:0] D_CACHE_NOP   = 2'd0;
    localparam logic [1:0] D_CACHE_LOAD  = 2'd1;
    localparam logic [1:0] D_CACHE_STORE = 2'd2;

    localparam logic [1:0] D_CACHE_RESTING = 2'd0;
    localparam logic [1:0] D_CACHE_WORKING = 2'd1;
    localparam logic [1:0] D_CACHE_STALL   = 2'd2;
    localparam logic [1:0] L_S_FINISHED    = 2'd3;

    typedef enum logic [2:0] {
        VMC_IDLE  = 3'd0,
        VMC_SCAN  = 3'd1,
        VMC_ISSUE = 3'd2,
        VMC_WAIT  = 3'd3,
        VMC_DONE  = 3'd4
    } vmc_state_e;

    function automatic logic vsew_supported(input logic [2:0] vsew);
        return (vsew == ONE_BYTE) || (vsew == TWO_BYTE) || (vsew == FOUR_BYTE);
    endfunction

    // Element size in bytes; only meaningful for supported encodings.
    function automatic logic [2:0] unit_stride(input logic [2:0] vsew);
        case (vsew)
            ONE_BYTE: return 3'd1;
            TWO_BYTE: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/vector_mem_controller_addr_gen.sv
`timescale 1ns/1ps
// Element address/index generator: holds the current element index and byte address,
// and steps both by the effective stride whenever an element retires or is skipped.
module vmc_addr_gen
    import vector_mem_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  adv_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [2:0]            vsew_i,
    output logic [ADDR_WIDTH-1:0] cur_addr_o,
    output logic [IDX_WIDTH-1:0]  idx_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] eff_stride;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;

    // A zero stride means densely packed elements.
    assign eff_stride = (stride_q == '0) ? ADDR_WIDTH'(unit_stride(vsew_i)) : stride_q;

    always_comb begin
        addr_d   = addr_q;
        idx_d    = idx_q;
        stride_d = stride_q;
        if (start_i) begin
            addr_d   = base_i;
            idx_d    = '0;
            stride_d = stride_i;
        end else if (adv_i) begin
            addr_d = addr_q + eff_stride;
            idx_d  = idx_q + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            idx_q    <= '0;
            stride_q <= '0;
        end else begin
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            stride_q <= stride_d;
        end
    end

    assign cur_addr_o = addr_q;
    assign idx_o      = idx_q;

endmodule

// File: rtl/vector_mem_controller.sv
`timescale 1ns/1ps
// Scalar/vector load-store sequencer in front of DATA_CACHE: splits a request into
// single-element cache accesses and assembles load lanes into one register-wide word.
module vector_mem_controller
    import vector_mem_controller_pkg::*;
#(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int BYTE_SIZE        = 8,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic                          req_store,
    input  logic                          req_is_vector,
    input  logic [ADDR_WIDTH-1:0]         req_base_addr,
    input  logic [ADDR_WIDTH-1:0]         req_stride,
    input  logic [ENTRY_INDEX_SIZE:0]     req_vl,
    input  logic [2:0]                    req_vsew,
    input  logic [VECTOR_SIZE-1:0]        req_mask,
    input  logic [VECTOR_SIZE*LEN-1:0]    req_store_data,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [VECTOR_SIZE*LEN-1:0]    load_data,
    output logic [ADDR_WIDTH-1:0]         data_addr,
    output logic [2:0]                    data_type,
    output logic [LEN-1:0]                cache_written_data,
    output logic [1:0]                    cache_vis_signal,
    output logic [ENTRY_INDEX_SIZE:0]     length,
    input  logic [LEN-1:0]                cache_data,
    input  logic [1:0]                    d_cache_vis_status
);

    localparam int IW = ENTRY_INDEX_SIZE + 1;

    vmc_state_e state_q, state_d;

    logic                       store_q, vector_q;
    logic [2:0]                 vsew_q;
    logic [VECTOR_SIZE-1:0]     mask_q;
    logic [VECTOR_SIZE*LEN-1:0] store_data_q, load_data_q;
    logic [IW-1:0]              vl_q, eff_vl;
    logic                       error_q, error_d;
    logic                       start, adv, lane_wr;
    logic [ADDR_WIDTH-1:0]      cur_addr;
    logic [IW-1:0]              idx;
    logic [ENTRY_INDEX_SIZE-1:0] lane;
    logic [LEN-1:0]             lane_val;

    vmc_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .adv_i      (adv),
        .base_i     (req_base_addr),
        .stride_i   (req_stride),
        .vsew_i     (vsew_q),
        .cur_addr_o (cur_addr),
        .idx_o      (idx)
    );

    assign lane = idx[ENTRY_INDEX_SIZE-1:0];

    always_comb begin
        if (!req_is_vector)
            eff_vl = IW'(1);
        else if (req_vl > IW'(VECTOR_SIZE))
            eff_vl = IW'(VECTOR_SIZE);
        else
            eff_vl = req_vl;
    end

    always_comb begin
        lane_val = cache_data;
        case (vsew_q)
            ONE_BYTE: lane_val = LEN'(cache_data[BYTE_SIZE-1:0]);
            TWO_BYTE: lane_val = LEN'(cache_data[2*BYTE_SIZE-1:0]);
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= VMC_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        error_d = error_q;
        start   = 1'b0;
        adv     = 1'b0;
        lane_wr = 1'b0;
        case (state_q)
            VMC_IDLE: begin
                if (req_valid) begin
                    start   = 1'b1;
                    error_d = 1'b0;
                    state_d = VMC_SCAN;
                end
            end
            VMC_SCAN: begin
                if (idx == vl_q) begin
                    state_d = VMC_DONE;
                end else if (!vsew_supported(vsew_q)) begin
                    error_d = 1'b1;
                    state_d = VMC_DONE;
                end else if (vector_q && !mask_q[lane]) begin
                    adv = 1'b1;
                end else begin
                    state_d = VMC_ISSUE;
                end
            end
            VMC_ISSUE: begin
                // The cache takes the request only when it is idle; FINISHED from a
                // previous element still counts as busy here.
                if (d_cache_vis_status == D_CACHE_RESTING) state_d = VMC_WAIT;
            end
            VMC_WAIT: begin
                if (d_cache_vis_status == L_S_FINISHED) begin
                    adv     = 1'b1;
                    lane_wr = !store_q;
                    state_d = VMC_SCAN;
                end
            end
            VMC_DONE: state_d = VMC_IDLE;
            default:  state_d = VMC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_q      <= 1'b0;
            vector_q     <= 1'b0;
            vsew_q       <= ONE_BYTE;
            mask_q       <= '0;
            store_data_q <= '0;
            vl_q         <= '0;
            load_data_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            error_q <= error_d;
            if (start) begin
                store_q      <= req_store;
                vector_q     <= req_is_vector;
                vsew_q       <= req_vsew;
                mask_q       <= req_mask;
                store_data_q <= req_store_data;
                vl_q         <= eff_vl;
                load_data_q  <= '0;
            end else if (lane_wr) begin
                load_data_q[int'(lane)*LEN +: LEN] <= lane_val;
            end
        end
    end

    assign busy               = (state_q != VMC_IDLE);
    assign done               = (state_q == VMC_DONE);
    assign error              = error_q;
    assign load_data          = load_data_q;
    assign data_addr          = cur_addr;
    assign data_type          = vsew_q;
    assign cache_written_data = store_data_q[int'(lane)*LEN +: LEN];
    assign cache_vis_signal   = (state_q != VMC_ISSUE) ? D_CACHE_NOP
                              : (store_q ? D_CACHE_STORE : D_CACHE_LOAD);
    assign length             = IW'(1);

endmodule

// File: doc/vector_mem_controller.md
Name: vector_mem_controller

Overview:
- Sits between the execute/memory stage and DATA_CACHE.
- Accepts one scalar or vector load/store request. A vector request is split into per-element single accesses, issued one at a time over the data cache's request/status handshake.
- Assembles load results into a vector-register-wide word.
- Raises a one-cycle done pulse when the whole request has retired.

Parameters:
- ADDR_WIDTH, 17, byte address width (matches data cache).
- LEN, 32, element lane width in bits.
- BYTE_SIZE, 8, bits per byte.
- VECTOR_SIZE, 8, maximum elements per request (lanes).
- ENTRY_INDEX_SIZE, 3, log2(VECTOR_SIZE); element counters are ENTRY_INDEX_SIZE+1 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request strobe; sampled only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_is_vector  in  1  0 = scalar access (vl forced to 1, mask ignored).
- req_base_addr  in  ADDR_WIDTH  address of element 0.
- req_stride  in  ADDR_WIDTH  byte stride between elements; 0 selects unit stride (stride = element size).
- req_vl  in  ENTRY_INDEX_SIZE+1  element count.
- req_vsew  in  3  element size, shared ONE_BYTE/TWO_BYTE/FOUR_BYTE encoding.
- req_mask  in  VECTOR_SIZE  per-element enable (bit i = element i).
- req_store_data  in  VECTOR_SIZE*LEN  store data; lane i = bits [i*LEN +: LEN], low bits used.
- busy  out  1  high from request acceptance until the done pulse, inclusive.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; 1 = unsupported vsew.
- load_data  out  VECTOR_SIZE*LEN  assembled load result; stable from done until the next acceptance.
- data_addr  out  ADDR_WIDTH  to cache.
- data_type  out  3  to cache; equals latched vsew.
- cache_written_data  out  LEN  to cache; current element lane.
- cache_vis_signal  out  2  to cache; D_CACHE_LOAD/D_CACHE_STORE only in ISSUE, else D_CACHE_NOP.
- length  out  ENTRY_INDEX_SIZE+1  to cache; constant 1.
- cache_data  in  LEN  from cache; load element, normal byte order.
- d_cache_vis_status  in  2  from cache.

Behaviour:
Reset (rst at a clk edge):
- State goes to IDLE.
- busy=0, done=0, error=0, load_data=0, cache_vis_signal=NOP, data_addr=0, counters=0.
- Reset mid-operation abandons the request with no done pulse.
- The cache is not reset. The next issue waits for D_CACHE_RESTING, so an in-flight cache task drains safely.

IDLE:
- On req_valid, latch all req_* fields and set busy=1.
- Effective vl = 1 if scalar, else min(req_vl, VECTOR_SIZE).
- Element index i=0; cur_addr=base; load_data cleared to 0.
- Next state is SCAN.

SCAN (1 cycle per skipped element):
- If i == effective vl, go to DONE.
- If vsew is not ONE/TWO/FOUR_BYTE, go to DONE with error=1 and make no cache access.
- If element i is masked off (vector only): lane i stays 0, i++, cur_addr += stride, stay in SCAN.
- Otherwise go to ISSUE.

ISSUE:
- Drive data_addr=cur_addr, data_type=vsew, cache_written_data=lane i, and cache_vis_signal=LOAD or STORE combinationally from registers.
- At the first edge where d_cache_vis_status==D_CACHE_RESTING, the cache accepts and state goes to WAIT. Otherwise hold.

WAIT:
- cache_vis_signal=NOP.
- At the edge where status==L_S_FINISHED:
  - for a load, lane i of load_data = cache_data zero-extended per vsew;
  - i++, cur_addr += stride, go to SCAN.
- WORKING and STALL hold WAIT.

DONE:
- done=1 for exactly one cycle, busy still 1.
- Next state is IDLE with busy=0. A new request is accepted no earlier than the following edge.

Arithmetic and encoding:
- Stride and address arithmetic are modulo 2^ADDR_WIDTH (wrap-around allowed).
- Unit stride = 1, 2 or 4 bytes per vsew.

Boundary conditions:
- req_valid outside IDLE is ignored.
- vl=0, or all elements masked, produces done with no cache traffic.
- Cache status L_S_FINISHED seen while in ISSUE is treated as "not resting": hold until RESTING.

Decomposition:
- Add to the shared defines: the controller state encoding (IDLE/SCAN/ISSUE/WAIT/DONE).
- Reuse the existing vsew, D_CACHE_* request and status encodings unchanged.
- One natural sub-module, vmc_addr_gen: holds cur_addr and i, and computes the effective stride and next address. The remainder is the FSM and the lane assemble/select logic.

Test Plan:
- Scalar word load with the cache resting and hitting: base=0x100, vsew=FOUR_BYTE.
  -> One LOAD issue with data_addr=0x100 and length=1.
  -> Lane0=cache_data, other lanes 0, error=0, done pulses once.
- Vector unit-stride byte store: vl=4, base=0x1FFFF, mask=0xF, lanes=0x11,0x22,0x33,0x44.
  -> Four STORE issues at 0x1FFFF, 0x0, 0x1, 0x2 (address wrap).
  -> One done pulse.
- Strided halfword load: vl=3, stride=8, mask=0b101.
  -> Issues only at base and base+16.
  -> Lane1=0; lanes 0 and 2 zero-extended 16-bit values.
- Cache miss with D_CACHE_STALL held for 10 cycles.
  -> Controller holds WAIT with cache_vis_signal=NOP.
  -> No second issue until status L_S_FINISHED and then RESTING.
- vl=0, then vsew=EIGHT_BYTE with vl=2.
  -> Both requests give done with no cache request; error=0 then error=1.
- rst asserted during WAIT of element 2 of 4.
  -> Next cycle busy=0, done=0, cache_vis_signal=NOP.
  -> A new scalar load issues only after status returns to RESTING.
